// File: rtl/wb_cmd_master_if.sv
// Bundles the command, response and Wishbone master signals of wb_cmd_master.
// The master modport is the block's own view; slave is the view of whoever connects to it.
interface wb_cmd_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_adr_o;
    logic        wbm_we_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    logic        busy_o;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        output wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o, busy_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Command FIFO feeding a single-outstanding Wishbone master; one response per command, in order.
// Define WB_CMD_TIMEOUT_EN to compile in the REQ timeout counter (abort after TIMEOUT_CYC cycles).
module wb_cmd_master #(
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input logic               wbm_clk_i,
    input logic               wbm_rst_i,
    wb_cmd_master_if.master   bus
);
    localparam int AW = $clog2(CMD_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    cmd_t          fifo_mem [CMD_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push;
    state_t        state, state_next;
    logic          issue, finish, release_rsp, to_hit;

    assign full            = (count == (AW+1)'(CMD_DEPTH));
    assign empty           = (count == '0);
    assign push            = bus.cmd_valid_i && !full;
    assign head            = fifo_mem[rd_ptr];
    assign bus.cmd_ready_o = !full;
    assign bus.busy_o      = (state != IDLE) || !empty;

    always_ff @(posedge wbm_clk_i) begin
        if (wbm_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(issue);
        end
    end

    // NOTE: storage has no reset; an entry is only read after the count says it was written.
    always_ff @(posedge wbm_clk_i) begin
        if (push) fifo_mem[wr_ptr] <= '{we: bus.cmd_we_i, adr: bus.cmd_adr_i,
                                        dat: bus.cmd_dat_i, sel: bus.cmd_sel_i};
    end

`ifdef WB_CMD_TIMEOUT_EN
    logic [7:0] to_cnt;

    // Fires on the TIMEOUT_CYC-th REQ edge, so stb stays up exactly TIMEOUT_CYC cycles.
    assign to_hit = (to_cnt == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge wbm_clk_i) begin
        if (wbm_rst_i)                                        to_cnt <= '0;
        else if (issue)                                       to_cnt <= '0;
        else if (state == REQ && !bus.wbm_ack_i && !bus.wbm_err_i) to_cnt <= to_cnt + 8'd1;
    end
`else
    assign to_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    // NOTE: state and bus registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wbm_clk_i) begin
        if (wbm_rst_i) state <= IDLE;
        else           state <= state_next;
    end

    // NOTE: each comb process assigns defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = REQ;
            REQ:     if (bus.wbm_ack_i || bus.wbm_err_i || to_hit) state_next = RSP;
            RSP:     if (bus.rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        finish      = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE:    issue       = !empty;
            REQ:     finish      = bus.wbm_ack_i || bus.wbm_err_i || to_hit;
            RSP:     release_rsp = bus.rsp_ready_i;
            default: ;
        endcase
    end

    always_ff @(posedge wbm_clk_i) begin
        if (wbm_rst_i) begin
            bus.wbm_cyc_o     <= 1'b0;
            bus.wbm_stb_o     <= 1'b0;
            bus.wbm_we_o      <= 1'b0;
            bus.wbm_adr_o     <= '0;
            bus.wbm_dat_o     <= '0;
            bus.wbm_sel_o     <= '0;
            bus.rsp_valid_o   <= 1'b0;
            bus.rsp_dat_o     <= '0;
            bus.rsp_err_o     <= 1'b0;
            bus.rsp_timeout_o <= 1'b0;
        end else if (issue) begin
            bus.wbm_cyc_o <= 1'b1;
            bus.wbm_stb_o <= 1'b1;
            bus.wbm_we_o  <= head.we;
            bus.wbm_adr_o <= head.adr;
            bus.wbm_dat_o <= head.dat;
            bus.wbm_sel_o <= head.sel;
        end else if (finish) begin
            // err beats ack, and either beats a timeout landing on the same edge.
            bus.wbm_cyc_o     <= 1'b0;
            bus.wbm_stb_o     <= 1'b0;
            bus.rsp_valid_o   <= 1'b1;
            bus.rsp_err_o     <= bus.wbm_err_i || !bus.wbm_ack_i;
            bus.rsp_timeout_o <= to_hit && !bus.wbm_ack_i && !bus.wbm_err_i;
            bus.rsp_dat_o     <= (bus.wbm_ack_i && !bus.wbm_err_i && !bus.wbm_we_o) ? bus.wbm_dat_i : '0;
        end else if (release_rsp) begin
            bus.rsp_valid_o <= 1'b0;
        end
    end
endmodule
